// File: rtl/piano_play_ctrl_pkg.sv
// rtl/piano_play_ctrl_pkg.sv - shared note codes, LED patterns and FSM states for the piano
package piano_play_ctrl_pkg;

  localparam int DEF_STEP_W = 6;
  localparam int DEF_SONG_W = 2;

  localparam logic [3:0] NOTE_C5   = 4'd0;
  localparam logic [3:0] NOTE_B4   = 4'd1;
  localparam logic [3:0] NOTE_A4   = 4'd2;
  localparam logic [3:0] NOTE_G4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_D4   = 4'd6;
  localparam logic [3:0] NOTE_C4   = 4'd7;
  localparam logic [3:0] NOTE_NONE = 4'd8;

  localparam logic [7:0] LED_C5   = 8'b1000_0000;
  localparam logic [7:0] LED_B4   = 8'b0100_0000;
  localparam logic [7:0] LED_A4   = 8'b0010_0000;
  localparam logic [7:0] LED_G4   = 8'b0001_0000;
  localparam logic [7:0] LED_F4   = 8'b0000_1000;
  localparam logic [7:0] LED_E4   = 8'b0000_0100;
  localparam logic [7:0] LED_D4   = 8'b0000_0010;
  localparam logic [7:0] LED_C4   = 8'b0000_0001;
  localparam logic [7:0] LED_NONE = 8'b0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2
  } play_state_e;

  function automatic logic note_valid(input logic [3:0] note);
    return note <= NOTE_C4;
  endfunction

endpackage

// File: rtl/piano_play_ctrl_note_led_decode.sv
// rtl/piano_play_ctrl_note_led_decode.sv - 4-bit note code to one-hot LED pattern
module note_led_decode
  import piano_play_ctrl_pkg::*;
(
  input  logic [3:0] i_note,
  output logic [7:0] o_led
);

  always_comb begin
    o_led = LED_NONE;
    case (i_note)
      NOTE_C5: o_led = LED_C5;
      NOTE_B4: o_led = LED_B4;
      NOTE_A4: o_led = LED_A4;
      NOTE_G4: o_led = LED_G4;
      NOTE_F4: o_led = LED_F4;
      NOTE_E4: o_led = LED_E4;
      NOTE_D4: o_led = LED_D4;
      NOTE_C4: o_led = LED_C4;
      default: o_led = LED_NONE;
    endcase
  end

endmodule

// File: rtl/piano_play_ctrl.sv
// rtl/piano_play_ctrl.sv - song step sequencer and manual/auto note arbiter
module piano_play_ctrl
  import piano_play_ctrl_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int SONG_W = DEF_SONG_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_beat_tick,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause_tgl,
  input  logic              i_loop,
  input  logic [SONG_W-1:0] i_song_sel,
  input  logic [3:0]        i_key_note,
  input  logic [3:0]        i_song_note,
  input  logic              i_song_end,
  output logic [SONG_W-1:0] o_song_id,
  output logic [STEP_W-1:0] o_song_addr,
  output logic [3:0]        o_note,
  output logic [7:0]        o_led,
  output logic              o_playing,
  output logic              o_done
);

  play_state_e       r_state, w_state_nxt;
  logic [STEP_W-1:0] r_addr, w_addr_nxt;
  logic [SONG_W-1:0] r_song_id, w_song_id_nxt;
  logic [3:0]        r_note, w_note_nxt;
  logic [7:0]        r_led, w_led_nxt;
  logic              r_playing, r_done, w_done_nxt;
  logic              w_end;

  assign w_end = i_song_end | (&r_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_song_id <= '0;
      r_note    <= NOTE_NONE;
      r_led     <= LED_NONE;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_song_id <= w_song_id_nxt;
      r_note    <= w_note_nxt;
      r_led     <= w_led_nxt;
      r_playing <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  // One event per cycle, in priority order; lower-priority pulses in the same cycle are dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_song_id_nxt = r_song_id;
    w_done_nxt    = 1'b0;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '0;
    end else if (i_start) begin
      w_state_nxt   = ST_PLAY;
      w_addr_nxt    = '0;
      w_song_id_nxt = i_song_sel;
    end else if (i_pause_tgl) begin
      if (r_state == ST_PLAY)        w_state_nxt = ST_PAUSED;
      else if (r_state == ST_PAUSED) w_state_nxt = ST_PLAY;
    end else if (i_beat_tick && r_state == ST_PLAY) begin
      if (!w_end) begin
        w_addr_nxt = r_addr + STEP_W'(1);
      end else if (i_loop) begin
        w_addr_nxt = '0;
      end else begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Keys always win so manual play works over a running song.
  always_comb begin
    w_note_nxt = NOTE_NONE;
    if (note_valid(i_key_note))
      w_note_nxt = i_key_note;
    else if (r_state == ST_PLAY && note_valid(i_song_note))
      w_note_nxt = i_song_note;
  end

  note_led_decode u_led_decode (
    .i_note (w_note_nxt),
    .o_led  (w_led_nxt)
  );

  assign o_song_id   = r_song_id;
  assign o_song_addr = r_addr;
  assign o_note      = r_note;
  assign o_led       = r_led;
  assign o_playing   = r_playing;
  assign o_done      = r_done;

endmodule

// File: tb/tb_piano_play_ctrl.sv
// tb/tb_piano_play_ctrl.sv - scoreboard bench for piano_play_ctrl
module tb_piano_play_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_beat_tick = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_pause_tgl = 1'b0;
  logic       i_loop = 1'b0;
  logic [1:0] i_song_sel = '0;
  logic [3:0] i_key_note = 4'd8;
  logic [3:0] i_song_note;
  logic       i_song_end;
  logic [1:0] o_song_id;
  logic [5:0] o_song_addr;
  logic [3:0] o_note;
  logic [7:0] o_led;
  logic       o_playing, o_done;

  int n_checks = 0;
  int n_errors = 0;
  int end_at = 31;

  typedef struct packed {
    logic [5:0] addr;
    logic [1:0] id;
    logic [3:0] note;
    logic [7:0] led;
    logic       playing;
    logic       done;
  } exp_t;
  exp_t sb[$];

  int         m_state = 0;
  logic [5:0] m_addr = '0;
  logic [1:0] m_id = '0;

  always #5 i_clk = ~i_clk;

  function automatic logic [3:0] rom(input logic [1:0] id, input logic [5:0] addr);
    return 4'((int'(addr) * 3 + int'(id) * 5) % 11);
  endfunction

  assign i_song_note = rom(o_song_id, o_song_addr);
  assign i_song_end  = (int'(o_song_addr) == end_at);

  piano_play_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_beat_tick (i_beat_tick),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_pause_tgl (i_pause_tgl),
    .i_loop      (i_loop),
    .i_song_sel  (i_song_sel),
    .i_key_note  (i_key_note),
    .i_song_note (i_song_note),
    .i_song_end  (i_song_end),
    .o_song_id   (o_song_id),
    .o_song_addr (o_song_addr),
    .o_note      (o_note),
    .o_led       (o_led),
    .o_playing   (o_playing),
    .o_done      (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] led_of(input logic [3:0] n);
    return (n < 4'd8) ? (8'h80 >> n) : 8'h00;
  endfunction

  // Drive one cycle of stimulus and push what the outputs must be after the edge.
  task automatic step(input logic tick, input logic start, input logic stop,
                      input logic pause, input logic [1:0] sel, input logic [3:0] key);
    int         ns;
    logic [5:0] na;
    logic [1:0] nid;
    logic       nd, e;
    logic [3:0] sn, nn;
    exp_t       x;
    i_beat_tick = tick; i_start = start; i_stop = stop; i_pause_tgl = pause;
    i_song_sel = sel; i_key_note = key;
    ns = m_state; na = m_addr; nid = m_id; nd = 1'b0;
    if (stop) begin
      ns = 0; na = '0;
    end else if (start) begin
      ns = 1; na = '0; nid = sel;
    end else if (pause) begin
      if (m_state == 1) ns = 2;
      else if (m_state == 2) ns = 1;
    end else if (tick && m_state == 1) begin
      e = (int'(m_addr) == end_at) || (m_addr == 6'd63);
      if (!e) na = m_addr + 6'd1;
      else if (i_loop) na = '0;
      else begin ns = 0; na = '0; nd = 1'b1; end
    end
    sn = rom(m_id, m_addr);
    if (key < 4'd8) nn = key;
    else if (m_state == 1 && sn < 4'd8) nn = sn;
    else nn = 4'd8;
    x.addr = na; x.id = nid; x.note = nn; x.led = led_of(nn);
    x.playing = (ns != 0); x.done = nd;
    sb.push_back(x);
    m_state = ns; m_addr = na; m_id = nid;
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle(input logic [3:0] key);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, key);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd8);
  endtask

  task automatic start_song(input logic [1:0] sel);
    step(1'b0, 1'b1, 1'b0, 1'b0, sel, 4'd8);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("addr", 32'(o_song_addr), 32'(e.addr));
        chk("song_id", 32'(o_song_id), 32'(e.id));
        chk("note", 32'(o_note), 32'(e.note));
        chk("led", 32'(o_led), 32'(e.led));
        chk("playing", 32'(o_playing), 32'(e.playing));
        chk("done", 32'(o_done), 32'(e.done));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    repeat (3) @(posedge i_clk);
    #2;
    chk("rst_addr", 32'(o_song_addr), 32'd0);
    chk("rst_note", 32'(o_note), 32'd8);
    chk("rst_led", 32'(o_led), 32'd0);
    chk("rst_playing", 32'(o_playing), 32'd0);
    i_rst_n = 1'b1;
    idle(4'd8);

    // Song 1, five beats
    i_loop = 1'b0; end_at = 31;
    start_song(2'd1);
    for (int i = 0; i < 5; i++) begin
      ticks(1);
      idle(4'd8);
    end
    chk("t1_addr", 32'(o_song_addr), 32'd5);
    chk("t1_id", 32'(o_song_id), 32'd1);
    chk("t1_playing", 32'(o_playing), 32'd1);

    // SONG_END at 31 without loop
    ticks(26);
    chk("t2_addr31", 32'(o_song_addr), 32'd31);
    ticks(1);
    chk("t2_done", 32'(o_done), 32'd1);
    chk("t2_idle", 32'(o_playing), 32'd0);
    idle(4'd8);
    chk("t2_done_1cyc", 32'(o_done), 32'd0);

    // Same with loop
    i_loop = 1'b1;
    start_song(2'd2);
    ticks(32);
    chk("t2_loop_addr", 32'(o_song_addr), 32'd0);
    chk("t2_loop_play", 32'(o_playing), 32'd1);
    chk("t2_loop_done", 32'(o_done), 32'd0);

    // Address wrap end without SONG_END
    i_loop = 1'b0; end_at = -1;
    start_song(2'd3);
    ticks(63);
    chk("t3_addr63", 32'(o_song_addr), 32'd63);
    ticks(1);
    chk("t3_done", 32'(o_done), 32'd1);
    chk("t3_addr0", 32'(o_song_addr), 32'd0);
    idle(4'd8);

    // Pause freezes the step address
    end_at = 31;
    start_song(2'd0);
    ticks(10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd8);
    ticks(3);
    chk("t4_frozen", 32'(o_song_addr), 32'd10);
    chk("t4_silent", 32'(o_note), 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd8);
    ticks(1);
    chk("t4_resume", 32'(o_song_addr), 32'd11);

    // Key override
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3);
    chk("t5_key", 32'(o_note), 32'd3);
    chk("t5_led_g", 32'(o_led), 32'h10);
    chk("t5_adv", 32'(o_song_addr), 32'd12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd12);
    idle(4'd12);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd8);
    idle(4'd7);
    chk("t5_idle_key", 32'(o_note), 32'd7);
    chk("t5_idle_led", 32'(o_led), 32'h01);

    // Priority corners
    start_song(2'd1);
    ticks(4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd8);
    chk("t6_stop_wins", 32'(o_playing), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd8);
    chk("t6_start_tick", 32'(o_song_addr), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd8);

    // Randomised mix
    for (int i = 0; i < 300; i++) begin
      i_loop = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 30) == 0),
           1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 25) == 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-song
    i_loop = 1'b0;
    start_song(2'd3);
    ticks(20);
    chk("t6_addr20", 32'(o_song_addr), 32'd20);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(o_song_addr), 32'd0);
    chk("arst_id", 32'(o_song_id), 32'd0);
    chk("arst_note", 32'(o_note), 32'd8);
    chk("arst_led", 32'(o_led), 32'd0);
    chk("arst_playing", 32'(o_playing), 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    m_state = 0; m_addr = '0; m_id = '0;
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    idle(4'd8);
    idle(4'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
